// File: rtl/qcw_burst_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qcw_burst_sequencer_pkg : shared state encoding, default widths, helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package qcw_burst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int DEF_PHASE_W = 10;
  localparam int DEF_CYCLE_W = 16;
  localparam int BURST_CNT_W = 16;

  // Bits needed to hold the value max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qcw_burst_sequencer_holdoff_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qcw_burst_sequencer_holdoff_timer : loadable down-counter saturating at 0
// Rev 1.0
// ---------------------------------------------------------------------------
module qcw_burst_sequencer_holdoff_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/qcw_burst_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qcw_burst_sequencer : gates QCW burst triggers, ramps phase, handles faults
// Rev 1.0
// ---------------------------------------------------------------------------
module qcw_burst_sequencer
  import qcw_burst_sequencer_pkg::*;
#(
  parameter int PHASE_W       = DEF_PHASE_W,
  parameter int CYCLE_W       = DEF_CYCLE_W,
  parameter int PHASE_START   = 400,
  parameter int PHASE_END     = 50,
  parameter int PHASE_STEP    = 1,
  parameter int REP_PERIOD    = 2400000,
  parameter int DRAIN_TIMEOUT = 24000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   trigger,
  input  logic [CYCLE_W-1:0]     cfg_cycles,
  input  logic                   over_temp,
  input  logic                   fault_clear,
  input  logic                   driver_ready,
  input  logic                   driver_cycle_finished,
  input  logic                   driver_fault,
  output logic                   driver_start,
  output logic                   driver_halt,
  output logic [PHASE_W-1:0]     phase_shift,
  output logic [CYCLE_W-1:0]     cycle_limit,
  output logic                   busy,
  output logic                   fault_latched,
  output logic [BURST_CNT_W-1:0] burst_count
);

  localparam int HOLD_W  = cnt_width(REP_PERIOD);
  localparam int DRAIN_W = cnt_width(DRAIN_TIMEOUT);

  localparam logic [PHASE_W-1:0] PHASE_START_V = PHASE_W'(PHASE_START);
  localparam logic [PHASE_W-1:0] PHASE_END_V   = PHASE_W'(PHASE_END);
  localparam logic [PHASE_W-1:0] PHASE_STEP_V  = PHASE_W'(PHASE_STEP);
  localparam logic [PHASE_W:0]   PHASE_THRESH  = (PHASE_W + 1)'(PHASE_END + PHASE_STEP);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD     = HOLD_W'(REP_PERIOD - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD    = DRAIN_W'(DRAIN_TIMEOUT - 1);

  state_e                   state_d, state_q;
  logic                     start_d, start_q;
  logic                     halt_d, halt_q;
  logic                     halt_pulse;
  logic [PHASE_W-1:0]       phase_d, phase_q;
  logic [CYCLE_W-1:0]       cycle_limit_d, cycle_limit_q;
  logic [CYCLE_W-1:0]       cycles_done_d, cycles_done_q;
  logic [BURST_CNT_W-1:0]   burst_count_d, burst_count_q;
  logic                     busy_d, busy_q;
  logic                     fault_latched_d, fault_latched_q;

  logic                     hold_load;
  logic                     drain_load;
  logic [HOLD_W-1:0]        hold_count;
  logic [DRAIN_W-1:0]       drain_count;
  logic                     hold_zero;
  logic                     hold_last;
  logic                     drain_zero;
  logic [CYCLE_W-1:0]       cycles_inc;
  logic [PHASE_W-1:0]       phase_ramped;
  logic                     trig_ok;
  logic                     fault_hard;

  qcw_burst_sequencer_holdoff_timer #(
    .WIDTH (HOLD_W)
  ) u_rep_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .enable     (1'b1),
    .count      (hold_count)
  );

  qcw_burst_sequencer_holdoff_timer #(
    .WIDTH (DRAIN_W)
  ) u_drain_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (drain_load),
    .load_value (DRAIN_LOAD),
    .enable     (state_q == ST_DRAIN),
    .count      (drain_count)
  );

  assign hold_zero  = (hold_count == '0);
  assign hold_last  = (hold_count == HOLD_W'(1));
  assign drain_zero = (drain_count == '0);
  assign cycles_inc = cycles_done_q + CYCLE_W'(1);
  assign fault_hard = driver_fault | over_temp;

  // Compare before subtracting so the ramp can never wrap below the floor.
  assign phase_ramped = ({1'b0, phase_q} >= PHASE_THRESH) ? (phase_q - PHASE_STEP_V)
                                                          : PHASE_END_V;

  assign trig_ok = arm & trigger & driver_ready & ~over_temp & hold_zero
                 & (cfg_cycles != '0);

  always_comb begin
    state_d       = state_q;
    start_d       = 1'b0;
    halt_pulse    = 1'b0;
    phase_d       = phase_q;
    cycle_limit_d = cycle_limit_q;
    cycles_done_d = cycles_done_q;
    burst_count_d = burst_count_q;
    hold_load     = 1'b0;
    drain_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (driver_fault) begin
          state_d = ST_FAULT;
        end else if (trig_ok) begin
          state_d       = ST_START;
          start_d       = 1'b1;
          cycle_limit_d = cfg_cycles;
          cycles_done_d = '0;
          hold_load     = 1'b1;
        end
      end
      ST_START: begin
        if (fault_hard) begin
          state_d = ST_FAULT;
        end else if (!arm) begin
          state_d    = ST_DRAIN;
          halt_pulse = 1'b1;
          drain_load = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fault_hard) begin
          state_d = ST_FAULT;
        end else if (!arm) begin
          state_d    = ST_DRAIN;
          halt_pulse = 1'b1;
          drain_load = 1'b1;
        end else if (driver_cycle_finished) begin
          cycles_done_d = cycles_inc;
          phase_d       = phase_ramped;
          if (cycles_inc == cycle_limit_q) begin
            state_d    = ST_DRAIN;
            drain_load = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fault_hard) begin
          state_d = ST_FAULT;
        end else if (driver_ready) begin
          state_d       = ST_HOLDOFF;
          burst_count_d = burst_count_q + BURST_CNT_W'(1);
        end else if (drain_zero) begin
          state_d = ST_FAULT;
        end
      end
      ST_HOLDOFF: begin
        // Leave on the edge the holdoff reaches zero so IDLE can accept right away.
        if (driver_fault) begin
          state_d = ST_FAULT;
        end else if (hold_zero || hold_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clear && !over_temp && !driver_fault && driver_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    if (state_d == ST_IDLE) begin
      phase_d = PHASE_START_V;
    end

    halt_d          = halt_pulse | (state_d == ST_FAULT);
    busy_d          = (state_d != ST_IDLE);
    fault_latched_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      start_q         <= 1'b0;
      halt_q          <= 1'b0;
      phase_q         <= PHASE_START_V;
      cycle_limit_q   <= '0;
      cycles_done_q   <= '0;
      burst_count_q   <= '0;
      busy_q          <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_q         <= start_d;
      halt_q          <= halt_d;
      phase_q         <= phase_d;
      cycle_limit_q   <= cycle_limit_d;
      cycles_done_q   <= cycles_done_d;
      burst_count_q   <= burst_count_d;
      busy_q          <= busy_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign driver_start  = start_q;
  assign driver_halt   = halt_q;
  assign phase_shift   = phase_q;
  assign cycle_limit   = cycle_limit_q;
  assign busy          = busy_q;
  assign fault_latched = fault_latched_q;
  assign burst_count   = burst_count_q;

endmodule
`default_nettype wire
